// File: rtl/bnn_pkg.sv
// Shared BNN definitions: default widths, act/pool FSM states and feature bit indexing.
// Used by bnn_conv, bnn_act_pool and the classifier.
package bnn_pkg;

  localparam int BNN_DW  = 32;
  localparam int BNN_NCH = 3;

  typedef enum logic {ACC, HOLD} bnn_state_e;

  // Feature vector layout: pool window major, channel minor.
  function automatic int feat_bit(input int p, input int c, input int nch);
    return p * nch + c;
  endfunction

endpackage

// File: rtl/bnn_sign_unit.sv
// One channel of the activation/pool stage: sign compare against threshold and
// OR-accumulate over the pool window.
module bnn_sign_unit #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic [DW-1:0] thr,
  input  logic          acc_en,
  input  logic          commit,
  input  logic          clr,
  output logic          pool_bit
);

  logic b;
  logic pool_d, pool_q;

  assign b        = ($signed(din) >= $signed(thr));
  // Max-pool of binary values is an OR; includes the frame being accepted now.
  assign pool_bit = pool_q | b;

  always_comb begin
    pool_d = pool_q;
    if (clr)         pool_d = 1'b0;
    else if (acc_en) pool_d = commit ? 1'b0 : pool_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pool_q <= 1'b0;
    else        pool_q <= pool_d;
  end

endmodule

// File: rtl/bnn_act_pool.sv
// BNN sign activation + POOL-frame max-pool, packing NPOOL windows per channel into one feature vector.
// Optional runtime threshold programming via `define BNN_ACT_THR_PROG_EN.
module bnn_act_pool
  import bnn_pkg::*;
#(
  parameter int NCH   = BNN_NCH,
  parameter int DW    = BNN_DW,
  parameter int POOL  = 3,
  parameter int NPOOL = 12,
  parameter logic signed [DW-1:0] THR0 = '0,
  parameter logic signed [DW-1:0] THR1 = '0,
  parameter logic signed [DW-1:0] THR2 = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*DW-1:0]    conv_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [NCH*NPOOL-1:0] feat_out,
  output logic                 feat_valid,
  input  logic                 feat_ready
`ifdef BNN_ACT_THR_PROG_EN
  ,
  input  logic                 thr_we,
  input  logic [1:0]           thr_sel,
  input  logic [DW-1:0]        thr_wdata
`endif
);

  localparam int FCW = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int PIW = (NPOOL > 1) ? $clog2(NPOOL) : 1;
  localparam logic [FCW-1:0] FC_LAST = FCW'(POOL - 1);
  localparam logic [PIW-1:0] PI_LAST = PIW'(NPOOL - 1);

  bnn_state_e           state_d, state_q;
  logic [FCW-1:0]       frame_cnt_d, frame_cnt_q;
  logic [PIW-1:0]       pool_idx_d, pool_idx_q;
  logic [NCH*NPOOL-1:0] feat_d, feat_q;
  logic                 accept, commit;
  logic [NCH-1:0]       pool_bit;
  logic [NCH-1:0][DW-1:0] thr, thr_rst;

  genvar c;
  generate
    for (c = 0; c < NCH; c++) begin : g_ch
      assign thr_rst[c] = (c == 0) ? THR0 : (c == 1) ? THR1 : (c == 2) ? THR2 : '0;

      bnn_sign_unit #(.DW(DW)) u_sign (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (conv_in[c*DW +: DW]),
        .thr     (thr[c]),
        .acc_en  (accept),
        .commit  (commit),
        .clr     (flush),
        .pool_bit(pool_bit[c])
      );
    end
  endgenerate

`ifdef BNN_ACT_THR_PROG_EN
  logic [NCH-1:0][DW-1:0] thr_d, thr_q;

  always_comb begin
    thr_d = thr_q;
    if (thr_we && (int'(thr_sel) < NCH)) thr_d[thr_sel] = thr_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) thr_q <= thr_rst;
    else        thr_q <= thr_d;
  end

  // Compare uses the registered value, so a same-cycle write affects only later frames.
  assign thr = thr_q;
`else
  assign thr = thr_rst;
`endif

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    pool_idx_d  = pool_idx_q;
    feat_d      = feat_q;
    accept      = 1'b0;
    commit      = 1'b0;
    case (state_q)
      ACC: begin
        if (in_valid) begin
          accept = 1'b1;
          if (frame_cnt_q == FC_LAST) begin
            commit      = 1'b1;
            frame_cnt_d = '0;
            if (pool_idx_q == PI_LAST) begin
              pool_idx_d = '0;
              state_d    = HOLD;
            end else begin
              pool_idx_d = pool_idx_q + 1'b1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      HOLD:    if (feat_ready) state_d = ACC;
      default: state_d = ACC;
    endcase
    // Flush overrides both a same-cycle frame and a same-cycle vector handshake.
    if (flush) begin
      state_d     = ACC;
      frame_cnt_d = '0;
      pool_idx_d  = '0;
      accept      = 1'b0;
      commit      = 1'b0;
    end
    if (commit) begin
      for (int p = 0; p < NPOOL; p++)
        if (pool_idx_q == PIW'(p))
          for (int k = 0; k < NCH; k++) feat_d[feat_bit(p, k, NCH)] = pool_bit[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      frame_cnt_q <= '0;
      pool_idx_q  <= '0;
      feat_q      <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      pool_idx_q  <= pool_idx_d;
      feat_q      <= feat_d;
    end
  end

  assign in_ready   = (state_q == ACC);
  assign feat_valid = (state_q == HOLD);
  assign feat_out   = feat_q;

endmodule

// File: tb/tb_bnn_act_pool.sv
// Directed bench for bnn_act_pool: reset, sign/pool packing, backpressure, flush,
// and threshold programming when BNN_ACT_THR_PROG_EN is defined.
module tb_bnn_act_pool;

  localparam int NCH = 3, DW = 32, NPOOL = 12, NFR = 36;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH*DW-1:0]    conv_in;
  logic                 in_valid, in_ready, flush;
  logic [NCH*NPOOL-1:0] feat_out;
  logic                 feat_valid, feat_ready;
`ifdef BNN_ACT_THR_PROG_EN
  logic                 thr_we;
  logic [1:0]           thr_sel;
  logic [DW-1:0]        thr_wdata;
`endif

  int tests = 0, fails = 0;
  logic signed [DW-1:0] pat [NFR][NCH];

  always #5 clk = ~clk;

  bnn_act_pool dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .conv_in   (conv_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .feat_out  (feat_out),
    .feat_valid(feat_valid),
    .feat_ready(feat_ready)
`ifdef BNN_ACT_THR_PROG_EN
    ,
    .thr_we    (thr_we),
    .thr_sel   (thr_sel),
    .thr_wdata (thr_wdata)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic signed [DW-1:0] v);
    for (int i = 0; i < NFR; i++)
      for (int k = 0; k < NCH; k++) pat[i][k] = v;
  endtask

  // One accepted frame from pat[i]; bounded wait for in_ready.
  task automatic send_frame(input int i);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("rdy_timeout", 64'(in_ready), 64'd1);
    conv_in  = {pat[i][2], pat[i][1], pat[i][0]};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_frame(i);
  endtask

  // Send all 36 frames, checking that the vector appears exactly after the last one.
  task automatic send_utt(input string tag, input logic [63:0] exp);
    send_range(0, NFR - 2);
    chk({tag, "_early"}, 64'(feat_valid), 64'd0);
    send_frame(NFR - 1);
    chk({tag, "_valid"}, 64'(feat_valid), 64'd1);
    chk({tag, "_feat"}, 64'(feat_out), exp);
  endtask

  task automatic consume();
    feat_ready = 1'b1;
    tick();
    feat_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; feat_ready = 1'b0; conv_in = '0;
`ifdef BNN_ACT_THR_PROG_EN
    thr_we = 1'b0; thr_sel = '0; thr_wdata = '0;
`endif
    tick(); tick();
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(feat_valid), 64'd0);
    chk("rst_feat", 64'(feat_out), 64'd0);
    rst_n = 1'b1;
    tick();

    // Partial utterance of all-positive frames, then async reset mid-run.
    fill(32'sd5);
    send_range(0, 9);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_valid", 64'(feat_valid), 64'd0);
    chk("mid_rst_feat", 64'(feat_out), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single positive sample in frame 0, channel 0.
    fill(-32'sd1);
    pat[0][0] = 32'sd5;
    send_utt("one_hot", 64'h1);
    chk("hold_ready", 64'(in_ready), 64'd0);
    consume();
    chk("cons_valid", 64'(feat_valid), 64'd0);
    chk("cons_ready", 64'(in_ready), 64'd1);

    // Equality sets, most negative clears, most positive sets.
    fill(-32'sd1);
    for (int i = 0; i < NFR; i++) pat[i][2] = 32'sh8000_0000;
    pat[4][1]  = 32'sd0;
    pat[35][0] = 32'sh7FFF_FFFF;
    send_utt("eq_sign", 64'h2_0000_0010);

    // Backpressure with frames offered while holding.
    conv_in  = {32'sd5, 32'sd5, 32'sd5};
    in_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      chk("bp_ready", 64'(in_ready), 64'd0);
      chk("bp_feat", 64'(feat_out), 64'h2_0000_0010);
    end
    in_valid = 1'b0;
    consume();
    chk("bp_rel_valid", 64'(feat_valid), 64'd0);
    chk("bp_rel_ready", 64'(in_ready), 64'd1);
    fill(-32'sd1);
    pat[35][2] = 32'sd1;
    send_utt("bp_next", 64'h8_0000_0000);
    consume();

    // Flush after 20 frames, colliding with a frame.
    fill(32'sd5);
    send_range(0, 19);
    conv_in  = {32'sd5, 32'sd5, 32'sd5};
    in_valid = 1'b1;
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("fl_ready", 64'(in_ready), 64'd1);
    chk("fl_valid", 64'(feat_valid), 64'd0);
    fill(-32'sd1);
    pat[0][1] = 32'sd7;
    send_utt("fl_after", 64'h2);

    // Flush in HOLD wins over feat_ready.
    feat_ready = 1'b1;
    flush      = 1'b1;
    tick();
    feat_ready = 1'b0;
    flush      = 1'b0;
    chk("fl_hold_valid", 64'(feat_valid), 64'd0);
    chk("fl_hold_ready", 64'(in_ready), 64'd1);
    fill(-32'sd1);
    send_utt("fl_clean", 64'h0);
    consume();

`ifdef BNN_ACT_THR_PROG_EN
    // Write thr[1]=100 in the same cycle as frame 0 (ch1=50, old threshold 0 applies).
    fill(-32'sd1);
    pat[0][1] = 32'sd50;
    pat[3][1] = 32'sd99;
    pat[6][1] = 32'sd100;
    thr_we = 1'b1; thr_sel = 2'd1; thr_wdata = 32'sd100;
    send_frame(0);
    thr_we = 1'b1; thr_sel = 2'd3; thr_wdata = 32'sd1000;
    send_frame(1);
    thr_we = 1'b0;
    send_range(2, NFR - 2);
    chk("thr_early", 64'(feat_valid), 64'd0);
    send_frame(NFR - 1);
    chk("thr_valid", 64'(feat_valid), 64'd1);
    chk("thr_feat", 64'(feat_out), 64'h82);
    consume();
    // Reset restores the default threshold of 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    fill(-32'sd1);
    pat[6][1] = 32'sd50;
    send_utt("thr_rst", 64'h80);
    consume();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
